// File: rtl/smp_pkg.sv
// ---------------------------------------------------------------------------
// smp_pkg
// Declarations shared by the memory bus interface and its address register:
// the access state enum, the default widths, and the value returned to the
// internal bus when a memory access times out.
// ---------------------------------------------------------------------------
package smp_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_BUS_W  = 16;

    // Read data substituted for a memory that never acknowledged.
    localparam logic [DEF_DATA_W-1:0] ERR_RDATA = '1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RD_DONE,
        WR_DONE
    } state_t;

endpackage

// File: rtl/mem_bus_interface_address_register.sv
// ---------------------------------------------------------------------------
// address_register
// Holds the memory address register AR.
//
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high; clears q
//   en    - update enable; the top ties this to ~stall
//   load  - load q from d (wins over inc)
//   inc   - increment q, wrapping from all-ones to zero
//   d     - load value
//   q     - current register value
// ---------------------------------------------------------------------------
module address_register
    import smp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    // Load beats increment; the natural overflow of the adder gives the wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            if (load) begin
                q <= d;
            end else if (inc) begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_interface.sv
// ---------------------------------------------------------------------------
// mem_bus_interface
// Bridges the control unit's memory micro-operations to an external memory
// with a req/ack handshake. Owns AR, registers the request towards memory,
// buffers read data for the internal bus and raises stall while an access is
// outstanding so the time counter holds its T-state.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   ARload, ARinc         - load AR from bus_in / increment AR
//   MEMbus                - read request (memory data wanted on the bus)
//   BUSmem, we            - write request, qualified by we
//   bus_in                - internal bus value (address or write data)
//   bus_out, bus_out_en   - zero-extended read data and its valid flag
//   stall                 - freeze time counter and control-driven loads
//   ar                    - current AR value
//   mem_req, mem_we       - registered request and write flag
//   mem_addr, mem_wdata   - registered address and write data
//   mem_rdata, mem_ack    - memory response
//   bus_err               - sticky flag, set when an access times out
// ---------------------------------------------------------------------------
module mem_bus_interface
    import smp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BUS_W   = DEF_BUS_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ARload,
    input  logic              ARinc,
    input  logic              MEMbus,
    input  logic              BUSmem,
    input  logic              we,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [BUS_W-1:0]  bus_out,
    output logic              bus_out_en,
    output logic              stall,
    output logic [ADDR_W-1:0] ar,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] read_buf;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wr_start;
    logic              rd_start;
    logic              in_wait;
    logic              timed_out;
    logic              done_now;

    // A write wins when the control unit asks for both directions at once.
    assign wr_start  = BUSmem & we;
    assign rd_start  = MEMbus & ~wr_start;
    assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
    assign timed_out = in_wait & ~mem_ack & (wait_cnt == CNT_LAST);
    assign done_now  = in_wait & (mem_ack | timed_out);

    // AR only moves while the time counter is running, so an ARinc issued
    // alongside MEMbus lands in the DONE cycle, after mem_addr was captured.
    address_register #(
        .ADDR_W (ADDR_W)
    ) u_ar (
        .clock (clock),
        .reset (reset),
        .en    (~stall),
        .load  (ARload),
        .inc   (ARinc),
        .d     (bus_in[ADDR_W-1:0]),
        .q     (ar)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stall is combinational in IDLE so the request cycle itself is frozen;
    // DONE states always fall back to IDLE so each access needs a fresh start.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        bus_out    = '0;
        bus_out_en = 1'b0;
        case (state)
            IDLE: begin
                stall = rd_start | wr_start;
                if (wr_start) begin
                    next_state = WR_WAIT;
                end else if (rd_start) begin
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (done_now) begin
                    next_state = RD_DONE;
                end
            end
            WR_WAIT: begin
                stall = 1'b1;
                if (done_now) begin
                    next_state = WR_DONE;
                end
            end
            RD_DONE: begin
                bus_out    = BUS_W'(read_buf);
                bus_out_en = MEMbus;
                next_state = IDLE;
            end
            WR_DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A timeout completes the access like an ack but returns all-ones data
    // and latches bus_err, which only reset clears.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            read_buf  <= '0;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
        end else if ((state == IDLE) && (rd_start || wr_start)) begin
            mem_req  <= 1'b1;
            mem_addr <= ar;
            wait_cnt <= '0;
            if (wr_start) begin
                mem_we    <= 1'b1;
                mem_wdata <= bus_in[DATA_W-1:0];
            end
        end else if (in_wait) begin
            if (done_now) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (timed_out) begin
                    read_buf <= {DATA_W{1'b1}};
                    bus_err  <= 1'b1;
                end else if (state == RD_WAIT) begin
                    read_buf <= mem_rdata;
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_interface.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_interface
// Drives whole memory transactions (optional AR load, then a read or write
// held until stall drops) against an acknowledging memory model, and compares
// the observed transaction with a transaction-level prediction.
// ---------------------------------------------------------------------------
module tb_mem_bus_interface;

    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        ARload;
    logic        ARinc;
    logic        MEMbus;
    logic        BUSmem;
    logic        we;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_out_en;
    logic        stall;
    logic [15:0] ar;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        load;
        logic [15:0] load_val;
        logic        rd;
        logic        wr;
        logic [15:0] wdata;
        int          ack_delay;
        logic [7:0]  rdata;
        logic        inc;
    } txn_t;

    typedef struct {
        int          stall_cycles;
        logic [15:0] addr;
        logic        mwe;
        logic [7:0]  wdata;
        logic [15:0] bus_out;
        logic        en;
        logic [15:0] ar_after;
        logic        err;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    mem_bus_interface #(
        .ADDR_W  (16),
        .DATA_W  (8),
        .BUS_W   (16),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ARload     (ARload),
        .ARinc      (ARinc),
        .MEMbus     (MEMbus),
        .BUSmem     (BUSmem),
        .we         (we),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_out_en (bus_out_en),
        .stall      (stall),
        .ar         (ar),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .bus_err    (bus_err)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drop_inputs();
        ARload = 1'b0;
        ARinc  = 1'b0;
        MEMbus = 1'b0;
        BUSmem = 1'b0;
        we     = 1'b0;
        bus_in = '0;
    endtask

    // Transaction-level prediction: stall covers the request cycle plus every
    // wait cycle up to the ack (or TIMEOUT cycles), AR moves only afterwards.
    function automatic exp_t predict(input txn_t t, input logic [15:0] ar_now,
                                     input logic err_now);
        exp_t e;
        logic [15:0] a;
        bit to;
        a  = t.load ? t.load_val : ar_now;
        to = (t.ack_delay >= TIMEOUT);
        e.stall_cycles = 1 + (to ? TIMEOUT : t.ack_delay + 1);
        e.addr     = a;
        e.mwe      = t.wr;
        e.wdata    = t.wr ? t.wdata[7:0] : 8'h00;
        e.bus_out  = t.wr ? 16'h0000 : {8'h00, (to ? 8'hFF : t.rdata)};
        e.en       = !t.wr && t.rd;
        e.ar_after = a + (t.inc ? 16'd1 : 16'd0);
        e.err      = err_now | to;
        return e;
    endfunction

    // Runs one transaction starting at a negedge in IDLE and returns just
    // after the negedge following the DONE cycle, with inputs released.
    task automatic apply_stimulus(input txn_t t, output exp_t o,
                                  output logic [15:0] ar_stalled, output int leak,
                                  output logic req_after, output logic we_after,
                                  output bit bounded);
        int  widx = 0;
        int  cyc = 0;
        bit  seen_req = 0;
        bit  finished = 0;
        o = '{default: 0};
        ar_stalled = '0;
        leak = 0;
        req_after = 1'b0;
        we_after = 1'b0;
        if (t.load) begin
            ARload = 1'b1;
            ARinc  = t.inc;
            bus_in = t.load_val;
            @(negedge clock);
            ARload = 1'b0;
            ARinc  = 1'b0;
        end
        MEMbus  = t.rd;
        BUSmem  = t.wr;
        we      = t.wr;
        bus_in  = t.wdata;
        ARinc   = t.inc;
        mem_ack = 1'b0;
        while (!finished && cyc < 100) begin
            #1;
            if (stall) begin
                o.stall_cycles++;
                if (bus_out_en) leak++;
                if (mem_req) begin
                    if (!seen_req) begin
                        seen_req   = 1;
                        o.addr     = mem_addr;
                        o.mwe      = mem_we;
                        o.wdata    = mem_wdata;
                        ar_stalled = ar;
                    end
                    mem_ack   = (widx == t.ack_delay);
                    mem_rdata = mem_ack ? t.rdata : 8'($urandom);
                    widx++;
                end else begin
                    mem_ack   = 1'($urandom_range(0, 1));
                    mem_rdata = 8'($urandom);
                end
                @(negedge clock);
                cyc++;
            end else begin
                finished  = 1;
                o.bus_out = bus_out;
                o.en      = bus_out_en;
                req_after = mem_req;
                we_after  = mem_we;
                mem_ack   = 1'b0;
                @(negedge clock);
                drop_inputs();
                #1;
                o.ar_after = ar;
                o.err      = bus_err;
            end
        end
        bounded = finished;
        if (!finished) begin
            drop_inputs();
            mem_ack = 1'b0;
        end
    endtask

    task automatic run_and_check(input txn_t t, input exp_t e, input string tag);
        exp_t        o;
        logic [15:0] ar_stalled;
        int          leak;
        logic        req_after;
        logic        we_after;
        bit          bounded;
        apply_stimulus(t, o, ar_stalled, leak, req_after, we_after, bounded);
        check_output({tag, ".completed"}, 32'(bounded), 32'd1);
        check_output({tag, ".stall_cycles"}, o.stall_cycles, e.stall_cycles);
        check_output({tag, ".mem_addr"}, o.addr, e.addr);
        check_output({tag, ".mem_we"}, o.mwe, e.mwe);
        if (t.wr) check_output({tag, ".mem_wdata"}, o.wdata, e.wdata);
        check_output({tag, ".ar_while_stalled"}, ar_stalled, e.addr);
        check_output({tag, ".bus_out"}, o.bus_out, e.bus_out);
        check_output({tag, ".bus_out_en"}, o.en, e.en);
        check_output({tag, ".en_during_stall"}, leak, 0);
        check_output({tag, ".req_after"}, {req_after, we_after}, 2'b00);
        check_output({tag, ".ar_after"}, o.ar_after, e.ar_after);
        check_output({tag, ".bus_err"}, o.err, e.err);
    endtask

    task automatic do_reset();
        drop_inputs();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_output("reset.ar", ar, 16'h0000);
        check_output("reset.mem_req_we", {mem_req, mem_we}, 2'b00);
        check_output("reset.mem_addr", mem_addr, 16'h0000);
        check_output("reset.mem_wdata", mem_wdata, 8'h00);
        check_output("reset.bus_out", {bus_out, bus_out_en}, 17'h0);
        check_output("reset.stall_err", {stall, bus_err}, 2'b00);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs[7];
        txn_t        t;
        exp_t        e;
        logic [15:0] model_ar;
        logic        model_err;
        int          bad;

        // Directed transactions with hand-computed results, applied in order
        // from reset (AR and bus_err carry over between entries).
        vecs[0] = '{'{1, 16'h0040, 1, 0, 16'h0000, 0, 8'hA5, 0},
                    '{2, 16'h0040, 0, 8'h00, 16'h00A5, 1, 16'h0040, 0}};
        vecs[1] = '{'{1, 16'h0100, 0, 1, 16'h1234, 2, 8'h00, 0},
                    '{4, 16'h0100, 1, 8'h34, 16'h0000, 0, 16'h0100, 0}};
        vecs[2] = '{'{1, 16'hFFFF, 1, 0, 16'h0000, 1, 8'h3C, 1},
                    '{3, 16'hFFFF, 0, 8'h00, 16'h003C, 1, 16'h0000, 0}};
        vecs[3] = '{'{0, 16'h0000, 1, 1, 16'h55AA, 0, 8'h99, 0},
                    '{2, 16'h0000, 1, 8'hAA, 16'h0000, 0, 16'h0000, 0}};
        vecs[4] = '{'{1, 16'h0200, 1, 0, 16'h0000, 20, 8'h12, 0},
                    '{16, 16'h0200, 0, 8'h00, 16'h00FF, 1, 16'h0200, 1}};
        vecs[5] = '{'{0, 16'h0000, 1, 0, 16'h0000, 0, 8'h11, 1},
                    '{2, 16'h0200, 0, 8'h00, 16'h0011, 1, 16'h0201, 1}};
        vecs[6] = '{'{0, 16'h0000, 0, 1, 16'hC3C3, 20, 8'h00, 0},
                    '{16, 16'h0201, 1, 8'hC3, 16'h0000, 0, 16'h0201, 1}};

        reset = 1'b1;
        drop_inputs();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            run_and_check(vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a write, then acks that arrive while idle.
        ARload = 1'b1;
        bus_in = 16'h0300;
        @(negedge clock);
        ARload = 1'b0;
        BUSmem = 1'b1;
        we     = 1'b1;
        bus_in = 16'hBEEF;
        @(negedge clock);
        #1;
        check_output("midreset.req_before", {mem_req, mem_we, stall}, 3'b111);
        @(negedge clock);
        reset = 1'b1;
        drop_inputs();
        @(negedge clock);
        #1;
        check_output("midreset.mem_req", mem_req, 1'b0);
        check_output("midreset.stall", stall, 1'b0);
        check_output("midreset.ar", ar, 16'h0000);
        check_output("midreset.bus_err", bus_err, 1'b0);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            if (mem_req || stall || bus_out_en || bus_err) bad++;
        end
        check_output("stray_ack.ignored", bad, 0);
        mem_ack = 1'b0;
        @(negedge clock);
        t = '{0, 16'h0000, 1, 0, 16'h0000, 0, 8'h12, 0};
        e = '{2, 16'h0000, 0, 8'h00, 16'h0012, 1, 16'h0000, 0};
        run_and_check(t, e, "after_reset_read");

        // Randomised transactions against the transaction-level model.
        do_reset();
        model_ar  = 16'h0000;
        model_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind        = $urandom_range(0, 2);
            t.load      = 1'($urandom_range(0, 1));
            t.load_val  = 16'($urandom);
            t.rd        = (kind != 1);
            t.wr        = (kind != 0);
            t.wdata     = 16'($urandom);
            t.ack_delay = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
            t.rdata     = 8'($urandom);
            t.inc       = 1'($urandom_range(0, 1));
            e = predict(t, model_ar, model_err);
            run_and_check(t, e, $sformatf("rand%0d", i));
            model_ar  = e.ar_after;
            model_err = e.err;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
